// File: rtl/multi_byte_add_ctrl_pkg.sv
// Shared types and constants for the multi-byte add/subtract controller and its byte adder.
package multi_byte_add_ctrl_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   typedef logic req_id_t;

endpackage

// File: rtl/multi_byte_add_ctrl_byte_adder.sv
// Purely combinational 8-bit ripple-carry adder shared by the controller, one byte per cycle.
module multi_byte_add_ctrl_byte_adder
   import multi_byte_add_ctrl_pkg::*;
(
   input  logic [BYTE_W-1:0] a_i,
   input  logic [BYTE_W-1:0] b_i,
   input  logic              cin_i,
   output logic [BYTE_W-1:0] sum_o,
   output logic              cout_o
);

   logic carry;

   // NOTE: carry is a blocking temporary that ripples bit to bit inside one combinational pass.
   always_comb begin
      carry = cin_i;
      sum_o = '0;
      for (int i = 0; i < BYTE_W; i++) begin
         sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
         carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
      end
      cout_o = carry;
   end

endmodule

// File: rtl/multi_byte_add_ctrl.sv
// Two-requester round-robin controller that sequences NBYTES-wide add/sub through one byte adder,
// LSB first, carrying between bytes only through carry_q.
module multi_byte_add_ctrl
   import multi_byte_add_ctrl_pkg::*;
#(
   parameter int NBYTES = 4
) (
   input  logic                     clk,
   input  logic                     rst,

   input  logic                     req0_valid,
   output logic                     req0_ready,
   input  logic [BYTE_W*NBYTES-1:0] req0_a,
   input  logic [BYTE_W*NBYTES-1:0] req0_b,
   input  logic                     req0_sub,

   input  logic                     req1_valid,
   output logic                     req1_ready,
   input  logic [BYTE_W*NBYTES-1:0] req1_a,
   input  logic [BYTE_W*NBYTES-1:0] req1_b,
   input  logic                     req1_sub,

   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [BYTE_W*NBYTES-1:0] rsp_sum,
   output logic                     rsp_cout,
   output logic                     rsp_id
);

   localparam int W     = BYTE_W * NBYTES;
   localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

   state_e           state_q, state_d;
   logic [W-1:0]     a_q, a_d;
   logic [W-1:0]     b_q, b_d;
   logic [W-1:0]     res_q, res_d;
   logic             carry_q, carry_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   req_id_t          id_q, id_d;
   req_id_t          last_grant_q, last_grant_d;

   logic             grant_vld;
   req_id_t          grant_id;
   logic [W-1:0]     sel_a;
   logic [W-1:0]     sel_b;
   logic             sel_sub;

   logic [BYTE_W-1:0] byte_a, byte_b, byte_sum;
   logic              byte_cout;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      grant_vld = 1'b0;
      grant_id  = 1'b0;
      if (state_q == IDLE) begin
         case ({req1_valid, req0_valid})
            2'b01: begin grant_vld = 1'b1; grant_id = 1'b0;          end
            2'b10: begin grant_vld = 1'b1; grant_id = 1'b1;          end
            2'b11: begin grant_vld = 1'b1; grant_id = ~last_grant_q; end
            default: ;
         endcase
      end
   end

   assign req0_ready = grant_vld && (grant_id == 1'b0);
   assign req1_ready = grant_vld && (grant_id == 1'b1);

   assign sel_a   = grant_id ? req1_a   : req0_a;
   assign sel_b   = grant_id ? req1_b   : req0_b;
   assign sel_sub = grant_id ? req1_sub : req0_sub;

   assign byte_a = a_q[idx_q*BYTE_W +: BYTE_W];
   assign byte_b = b_q[idx_q*BYTE_W +: BYTE_W];

   multi_byte_add_ctrl_byte_adder u_byte_adder (
      .a_i    (byte_a),
      .b_i    (byte_b),
      .cin_i  (carry_q),
      .sum_o  (byte_sum),
      .cout_o (byte_cout)
   );

   always_comb begin
      state_d      = state_q;
      a_d          = a_q;
      b_d          = b_q;
      res_d        = res_q;
      carry_d      = carry_q;
      idx_d        = idx_q;
      id_d         = id_q;
      last_grant_d = last_grant_q;

      case (state_q)
         IDLE: begin
            if (grant_vld) begin
               // Subtract is a + ~b + 1: invert b once here and seed the carry with 1.
               a_d          = sel_a;
               b_d          = sel_sub ? ~sel_b : sel_b;
               carry_d      = sel_sub;
               id_d         = grant_id;
               last_grant_d = grant_id;
               idx_d        = '0;
               state_d      = RUN;
            end
         end
         RUN: begin
            res_d[idx_q*BYTE_W +: BYTE_W] = byte_sum;
            carry_d = byte_cout;
            idx_d   = idx_q + IDX_W'(1);
            if (idx_q == LAST_IDX) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples the same pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         a_q          <= '0;
         b_q          <= '0;
         res_q        <= '0;
         carry_q      <= 1'b0;
         idx_q        <= '0;
         id_q         <= 1'b0;
         last_grant_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         a_q          <= a_d;
         b_q          <= b_d;
         res_q        <= res_d;
         carry_q      <= carry_d;
         idx_q        <= idx_d;
         id_q         <= id_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign rsp_valid = (state_q == DONE);
   assign rsp_sum   = res_q;
   assign rsp_cout  = carry_q;
   assign rsp_id    = id_q;

endmodule

// File: tb/tb_multi_byte_add_ctrl.sv
// Scoreboard bench: directed operations push hand-computed results; a negedge monitor pops on each handshake.
module tb_multi_byte_add_ctrl;

   localparam int NBYTES = 4;
   localparam int W      = 8 * NBYTES;

   logic         clk;
   logic         rst;
   logic         req0_valid, req0_ready, req0_sub;
   logic [W-1:0] req0_a, req0_b;
   logic         req1_valid, req1_ready, req1_sub;
   logic [W-1:0] req1_a, req1_b;
   logic         rsp_valid, rsp_ready, rsp_cout, rsp_id;
   logic [W-1:0] rsp_sum;

   multi_byte_add_ctrl #(.NBYTES(NBYTES)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_sub   (req0_sub),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_sub   (req1_sub),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_sum    (rsp_sum),
      .rsp_cout   (rsp_cout),
      .rsp_id     (rsp_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int tests = 0;
   int fails = 0;
   int rsp_seen = 0;

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
      logic         id;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      tests++;
      fails++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   // Monitor: every accepted response is compared against the head of the scoreboard.
   always @(negedge clk) begin
      if (!rst && rsp_valid && rsp_ready) begin
         rsp_seen++;
         if (exp_q.size() == 0) begin
            fail_now("rsp_unexpected");
         end else begin
            mon_e = exp_q.pop_front();
            check("rsp_sum",  64'(rsp_sum),  64'(mon_e.sum));
            check("rsp_cout", 64'(rsp_cout), 64'(mon_e.cout));
            check("rsp_id",   64'(rsp_id),   64'(mon_e.id));
         end
      end
   end

   task automatic push_exp(input logic [W-1:0] sum, input logic cout, input logic id);
      exp_t e;
      e.sum  = sum;
      e.cout = cout;
      e.id   = id;
      exp_q.push_back(e);
   endtask

   task automatic drive_req(input logic id, input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
      if (!id) begin
         req0_a = a; req0_b = b; req0_sub = sub; req0_valid = 1'b1;
      end else begin
         req1_a = a; req1_b = b; req1_sub = sub; req1_valid = 1'b1;
      end
   endtask

   task automatic drop_req(input logic id);
      if (!id) req0_valid = 1'b0;
      else     req1_valid = 1'b0;
   endtask

   task automatic wait_accept(input logic id, output int t_acc);
      t_acc = -1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (id ? req1_ready : req0_ready) begin
            t_acc = cyc;
            break;
         end
      end
      if (t_acc < 0) fail_now(id ? "accept_timeout_req1" : "accept_timeout_req0");
      @(posedge clk) #1;
      drop_req(id);
   endtask

   task automatic wait_rsp_valid(output int t_rsp);
      t_rsp = -1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (rsp_valid) begin
            t_rsp = cyc;
            break;
         end
      end
      if (t_rsp < 0) fail_now("rsp_valid_timeout");
   endtask

   task automatic wait_drain();
      bit drained;
      drained = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         if (exp_q.size() == 0) begin
            drained = 1'b1;
            break;
         end
      end
      if (!drained) fail_now("drain_timeout");
      #1;
   endtask

   task automatic run_op(input logic id, input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                         input logic [W-1:0] exp_sum, input logic exp_cout);
      int t_acc;
      @(posedge clk) #1;
      drive_req(id, a, b, sub);
      push_exp(exp_sum, exp_cout, id);
      wait_accept(id, t_acc);
      wait_drain();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t_acc, t_rsp, n_hs;
      bit arb_done;

      rst = 1'b1;
      rsp_ready = 1'b1;
      req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_sub = 1'b0;
      req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sub = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
      check("reset_rsp_sum",   64'(rsp_sum),   64'd0);
      check("reset_rsp_cout",  64'(rsp_cout),  64'd0);
      check("reset_rsp_id",    64'(rsp_id),    64'd0);

      // Both requesters valid from reset: grants alternate 0,1,0,1.
      @(posedge clk) #1;
      rst = 1'b0;
      drive_req(1'b0, 32'h0000_0010, 32'h0000_0020, 1'b0);
      drive_req(1'b1, 32'h0000_0100, 32'h0000_0001, 1'b1);
      push_exp(32'h0000_0030, 1'b0, 1'b0);
      push_exp(32'h0000_00FF, 1'b1, 1'b1);
      push_exp(32'h0000_0030, 1'b0, 1'b0);
      push_exp(32'h0000_00FF, 1'b1, 1'b1);
      @(negedge clk);
      check("first_tie_req0_ready", 64'(req0_ready), 64'd1);
      check("first_tie_req1_ready", 64'(req1_ready), 64'd0);
      n_hs = 0;
      arb_done = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (req0_ready && req1_ready) fail_now("both_ready");
         if (rsp_valid && rsp_ready) n_hs++;
         if (n_hs == 4) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            arb_done = 1'b1;
            break;
         end
      end
      if (!arb_done) fail_now("arb_timeout");
      wait_drain();
      check("arb_queue_empty", 64'(exp_q.size()), 64'd0);

      // Basic add with latency measurement.
      @(posedge clk) #1;
      drive_req(1'b0, 32'h0000_00FF, 32'h0000_0001, 1'b0);
      push_exp(32'h0000_0100, 1'b0, 1'b0);
      wait_accept(1'b0, t_acc);
      wait_rsp_valid(t_rsp);
      check("latency_accept_to_valid", 64'(t_rsp - t_acc), 64'(NBYTES + 1));
      wait_drain();

      run_op(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1);
      run_op(1'b0, 32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0);
      run_op(1'b0, 32'h0000_0007, 32'h0000_0005, 1'b1, 32'h0000_0002, 1'b1);

      // Backpressure: response held for 10 cycles while both requesters wait.
      @(posedge clk) #1;
      rsp_ready = 1'b0;
      drive_req(1'b0, 32'h1234_5678, 32'h1111_1111, 1'b0);
      push_exp(32'h2345_6789, 1'b0, 1'b0);
      wait_accept(1'b0, t_acc);
      wait_rsp_valid(t_rsp);
      @(posedge clk) #1;
      drive_req(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0);
      drive_req(1'b0, 32'h0000_0001, 32'h0000_0001, 1'b0);
      push_exp(32'h0000_0000, 1'b1, 1'b1);
      push_exp(32'h0000_0002, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp_rsp_valid",  64'(rsp_valid),  64'd1);
         check("bp_rsp_sum",    64'(rsp_sum),    64'h2345_6789);
         check("bp_rsp_cout",   64'(rsp_cout),   64'd0);
         check("bp_rsp_id",     64'(rsp_id),     64'd0);
         check("bp_req0_ready", 64'(req0_ready), 64'd0);
         check("bp_req1_ready", 64'(req1_ready), 64'd0);
      end
      @(posedge clk) #1;
      rsp_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("bp_idle_rsp_valid",  64'(rsp_valid),  64'd0);
      check("bp_next_req1_ready", 64'(req1_ready), 64'd1);
      check("bp_next_req0_ready", 64'(req0_ready), 64'd0);
      @(posedge clk) #1;
      drop_req(1'b1);
      wait_accept(1'b0, t_acc);
      wait_drain();

      // Reset at byte 2 of a run: no response may appear.
      @(posedge clk) #1;
      drive_req(1'b1, 32'h0000_AAAA, 32'h0000_5555, 1'b0);
      wait_accept(1'b1, t_acc);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (2) begin
         @(negedge clk);
         check("rst_no_rsp", 64'(rsp_valid), 64'd0);
      end
      @(posedge clk) #1;
      rst = 1'b0;
      drive_req(1'b1, 32'h0000_0010, 32'h0000_0001, 1'b0);
      drive_req(1'b0, 32'h0000_0003, 32'h0000_0004, 1'b0);
      push_exp(32'h0000_0007, 1'b0, 1'b0);
      @(negedge clk);
      check("post_rst_req0_ready", 64'(req0_ready), 64'd1);
      check("post_rst_req1_ready", 64'(req1_ready), 64'd0);
      @(posedge clk) #1;
      drop_req(1'b0);
      drop_req(1'b1);
      wait_drain();
      repeat (20) @(posedge clk);
      @(negedge clk);
      check("final_rsp_count",  64'(rsp_seen),     64'd12);
      check("final_queue_size", 64'(exp_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/multi_byte_add_ctrl.md
# multi_byte_add_ctrl

Sequencing controller and arbiter for the shared 8-bit ripple-carry adder. It accepts add or subtract requests from two requesters, each carrying NBYTES-wide operands, and grants them round-robin. It runs the granted operation through one 8-bit adder, one byte per cycle, LSB first, with the carry held in a register between cycles. It returns the full-width result and carry-out on a single response channel.

## Interface
- NBYTES, 4, operand width in bytes (≥1); W = 8*NBYTES
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a, req0_b  in  W  operands
- req0_sub  in  1  0: a+b, 1: a-b
- req1_valid / req1_ready / req1_a / req1_b / req1_sub  same as requester 0
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_sum  out  W  result
- rsp_cout  out  1  final carry (subtract: 1 = no borrow)
- rsp_id  out  1  requester that issued the result

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If exactly one reqN_valid is high, grant that requester.
  - If both are high, grant the requester not granted last.
  - reqN_ready is combinational, high only for the granted requester in IDLE.
  - On grant, latch a, b, sub and id; clear byte index to 0; go to RUN.
- Operand prep: for sub=1, latch b as ~b and preset the carry register to 1; otherwise preset carry to 0.
- RUN:
  - Each cycle, feed a[idx], b[idx] and the carry register to the byte adder.
  - Write the byte sum into result byte idx; load cout into the carry register; increment idx.
  - When idx == NBYTES-1, go to DONE.
- DONE:
  - rsp_valid=1; rsp_sum, rsp_cout and rsp_id are held stable until rsp_valid && rsp_ready.
  - On that handshake, go to IDLE the next cycle.
- last_grant updates only on an accept.
- No new request is accepted outside IDLE.
- Arithmetic is modulo 2^W. The carry chain crosses bytes through the register only, with no combinational path across bytes.

## Timing
- Reset values:
  - state=IDLE, last_grant=1 (requester 0 wins the first tie).
  - rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0.
  - req0_ready and req1_ready follow the IDLE rules from the first cycle after reset.
- Latency: accept in cycle T; RUN occupies T+1..T+NBYTES; rsp_valid rises at T+NBYTES+1.
- Throughput, with rsp_ready held high: one operation per NBYTES+2 cycles.
- Backpressure: DONE holds indefinitely; both requesters see ready=0 throughout.
- Reset asserted mid-RUN or in DONE: the operation is abandoned with no response, and reset values apply the next cycle.
- A request deasserted before being granted is simply not served; there is no latching before accept.
- NBYTES=1: RUN lasts exactly one cycle.

## Structure
- Shared package holds:
  - the state enum (IDLE/RUN/DONE);
  - the byte-width constant (8);
  - the requester-id type.
- Sub-module byte_adder: 8-bit a, b, cin in; 8-bit sum and cout out; purely combinational full-adder chain. Exactly one instance.
- The controller holds the operand registers, result register, carry register, byte index, and round-robin flag.

## Test plan
- Basic add: NBYTES=4, req0 a=0x0000_00FF, b=0x0000_0001, sub=0 → rsp_sum=0x0000_0100, rsp_cout=0, rsp_id=0, rsp_valid 5 cycles after accept.
- Full carry ripple: req1 a=0xFFFF_FFFF, b=0x0000_0001 → rsp_sum=0, rsp_cout=1, rsp_id=1.
- Subtract: req0 a=5, b=7, sub=1 → rsp_sum=0xFFFF_FFFE, rsp_cout=0. Then a=7, b=5 → rsp_sum=2, rsp_cout=1.
- Arbitration: both valid continuously from reset → grants alternate 0,1,0,1 over four operations, and rsp_id matches.
- Backpressure: hold rsp_ready=0 for 10 cycles in DONE → rsp outputs stable, req ready stay 0. Release → handshake, IDLE next cycle, next accept the cycle after.
- Reset mid-RUN: assert rst at byte 2 → no response ever appears. After reset, req1 and req0 both valid → req0 granted first.
